cordic_sched: RTL and testbench
===============================

# cordic_sched

Shared iterative CORDIC sine/cosine engine with a multi-requester scheduler. NREQ clients present angles on independent valid/ready ports. A round-robin arbiter grants one client at a time. The block then folds the angle into the convergence range and runs one micro-rotation per cycle on a single shift-add datapath. It returns cos/sin tagged with the client ID through a valid/ready result port. It replaces per-client unrolled pipelines wherever throughput allows one result every ITER+2 cycles.

## Interface
- NREQ, 4: number of requesters (2..8)
- ITER, 24: micro-rotations per operation (8..30)
- IDW, $clog2(NREQ): width of res_id
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-client angle valid
- req_theta  in  32*NREQ  client k at bits [32k+31:32k]; signed, LSB = π/2^31, range [−π, π)
- req_ready  out  NREQ  one-hot grant; combinational
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_id  out  IDW  index of the client that owns the result
- cos  out  32  signed Q2.30
- sin  out  32  signed Q2.30
- busy  out  1  high whenever state ≠ IDLE

## Operation
- **FSM states:**
  - IDLE: arbitrate among clients.
  - ROT: iterate.
  - DONE: present the result.
- **IDLE:** at most one req_ready bit is high, for the arbitration winner among the set req_valid bits. No bit is high when no client is valid.
  - A handshake (req_valid[k] && req_ready[k]) captures theta_k and k, applies the fold, clears iteration counter i, and moves to ROT.
- **Fold (decided on theta[31:30]):**
  - 01: z = theta − 2^30, (x, y) = (0, K).
  - 10: z = theta + 2^30, (x, y) = (0, −K).
  - otherwise: z = theta, (x, y) = (K, 0).
  - K = 0x26DD3B6A, which is round(0.6072529·2^30).
- **ROT, iteration i = 0..ITER−1:**
  - d = +1 if z ≥ 0, else −1.
  - x ← x − d·(y >>> i); y ← y + d·(x >>> i); z ← z − d·atan_i.
  - All terms use pre-update values, arithmetic shift, 32-bit two's complement.
  - atan_i = round(atan(2^−i)·2^31/π), held in an internal constant ROM; atan_0 = 0x20000000.
  - After iteration ITER−1, the FSM moves to DONE.
- **DONE:** res_valid = 1; cos = x, sin = y, res_id = captured k.
  - On res_valid && res_ready the FSM returns to IDLE.
  - cos, sin and res_id hold their values after the handshake until the next DONE.
- **Arbitration:** round-robin.
  - Pointer p starts at 0.
  - The winner is the first valid client scanning p, p+1, …, NREQ−1, 0, … (mod NREQ).
  - After a grant to client k, p ← (k+1) mod NREQ. p changes only on a grant.
- **Request rules:** clients must hold req_valid and req_theta stable until their grant. Ungranted requests are never dropped.
- **Reset:** applies in any state, including mid-ROT or DONE.
  - The in-flight operation is discarded.
  - State ← IDLE, p ← 0, res_valid ← 0, cos/sin/res_id ← 0, x/y/z/i ← 0.
  - busy and req_ready are 0 during the rst cycle.

## Timing
- Request handshake in cycle t; res_valid first high in cycle t+ITER+1.
- A result handshake in cycle u allows the next request handshake in cycle u+1 at the earliest. There is no bypass.
- Peak throughput: one result per ITER+2 cycles.
- req_ready depends combinationally on req_valid, state and p only. res_valid and all data outputs are registered.
- With res_ready held low, the block stays in DONE indefinitely, and outputs and p are frozen.
- Accuracy: |cos − ideal·2^30| and |sin − ideal·2^30| ≤ 2^(32−ITER) LSB (≤ 256 LSB at ITER=24).

## Configuration
- CORDIC_SCHED_RR_EN defined: round-robin arbitration as described.
- Not defined: fixed priority, where the lowest-index valid client always wins and p is not implemented.
- All other behaviour and timing are identical in both builds.

## Test plan
- **Zero angle:** client 0, theta = 0x00000000.
  - Expect res_valid at t+25 (ITER=24), res_id = 0, cos ≈ 0x40000000, sin ≈ 0 within 256 LSB.
- **Fold branches** (check tolerance on each):
  - theta = 0x20000000 → cos ≈ sin ≈ 0x2D413CCD.
  - theta = 0x60000000 → cos ≈ −0x2D413CCD, sin ≈ +0x2D413CCD.
  - theta = 0x80000000 → cos ≈ −0x40000000, sin ≈ 0.
- **Arbitration:** all 4 clients hold req_valid continuously, res_ready = 1.
  - With CORDIC_SCHED_RR_EN: grant order 0, 1, 2, 3, 0, with grants spaced exactly 26 cycles apart.
  - Without the macro: 0, 0, 0.
- **Backpressure:** hold res_ready = 0 for 10 cycles in DONE.
  - Expect res_valid, cos, sin and res_id stable and req_ready = 0.
  - Release: IDLE on the next cycle, next grant one cycle later.
- **Reset mid-operation:** assert rst at iteration 10.
  - Next cycle: busy = 0, res_valid = 0, outputs = 0.
  - A subsequent request from client 2 is granted first (p = 0, client 2 is the only valid one) and completes correctly.
- **Sweep:** 1000 random theta values from random clients with random res_ready stalls.
  - Every result matches a reference model within tolerance, with the correct res_id and no lost or duplicated requests.

Source files
------------

// File: rtl/cordic_sched.sv
// cordic_sched: shared iterative CORDIC sin/cos engine behind a request arbiter.
// Define CORDIC_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority.
module cordic_sched #(
   parameter int NREQ = 4,
   parameter int ITER = 24,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [32*NREQ-1:0]   req_theta,
   output logic [NREQ-1:0]      req_ready,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [IDW-1:0]       res_id,
   output logic [31:0]          cos,
   output logic [31:0]          sin,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

   localparam logic [31:0] K_C = 32'h26DD3B6A;

   state_t          state_q, state_d;
   logic [31:0]     x_q, x_d, y_q, y_d, z_q, z_d;
   logic [4:0]      i_q, i_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [IDW-1:0]  res_id_q, res_id_d;
   logic [31:0]     cos_q, cos_d, sin_q, sin_d;
   logic            res_valid_q, res_valid_d;

   logic            found;
   logic [IDW-1:0]  win;
   logic [31:0]     theta;
   logic [31:0]     atan;
   logic signed [31:0] xs, ys;
   int              base;

`ifdef CORDIC_SCHED_RR_EN
   logic [IDW-1:0]  p_q, p_d;
   assign base = int'(p_q);
`else
   assign base = 0;
`endif

   function automatic logic [31:0] atan_rom(input logic [4:0] idx);
      logic [31:0] v;
      case (idx)
         5'd0:    v = 32'h20000000;
         5'd1:    v = 32'h12E4051E;
         5'd2:    v = 32'h09FB385B;
         5'd3:    v = 32'h051111D4;
         5'd4:    v = 32'h028B0D43;
         5'd5:    v = 32'h0145D7E1;
         5'd6:    v = 32'h00A2F61E;
         5'd7:    v = 32'h00517C55;
         5'd8:    v = 32'h0028BE53;
         5'd9:    v = 32'h00145F2F;
         5'd10:   v = 32'h000A2F98;
         5'd11:   v = 32'h000517CC;
         5'd12:   v = 32'h00028BE6;
         5'd13:   v = 32'h000145F3;
         5'd14:   v = 32'h0000A2FA;
         5'd15:   v = 32'h0000517D;
         5'd16:   v = 32'h000028BE;
         5'd17:   v = 32'h0000145F;
         5'd18:   v = 32'h00000A30;
         5'd19:   v = 32'h00000518;
         5'd20:   v = 32'h0000028C;
         5'd21:   v = 32'h00000146;
         5'd22:   v = 32'h000000A3;
         5'd23:   v = 32'h00000051;
         5'd24:   v = 32'h00000029;
         5'd25:   v = 32'h00000014;
         5'd26:   v = 32'h0000000A;
         5'd27:   v = 32'h00000005;
         5'd28:   v = 32'h00000003;
         default: v = 32'h00000001;
      endcase
      return v;
   endfunction

   // Scan starting at base; fixed-priority build always starts at client 0.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (!found && req_valid[(base + j) % NREQ]) begin
            found = 1'b1;
            win   = IDW'((base + j) % NREQ);
         end
      end
   end

   assign theta = req_theta[32*win +: 32];
   assign xs    = $signed(x_q) >>> i_q;
   assign ys    = $signed(y_q) >>> i_q;
   assign atan  = atan_rom(i_q);

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      i_d         = i_q;
      id_d        = id_q;
      res_id_d    = res_id_q;
      cos_d       = cos_q;
      sin_d       = sin_q;
      res_valid_d = res_valid_q;
      req_ready   = '0;
`ifdef CORDIC_SCHED_RR_EN
      p_d         = p_q;
`endif
      case (state_q)
         IDLE: begin
            if (found && !rst) begin
               req_ready[win] = 1'b1;
               state_d        = ROT;
               i_d            = '0;
               id_d           = win;
`ifdef CORDIC_SCHED_RR_EN
               p_d = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
               // Quadrant fold keeps |z| inside the CORDIC convergence range.
               case (theta[31:30])
                  2'b01: begin
                     z_d = theta - 32'h40000000;
                     x_d = '0;
                     y_d = K_C;
                  end
                  2'b10: begin
                     z_d = theta + 32'h40000000;
                     x_d = '0;
                     y_d = -K_C;
                  end
                  default: begin
                     z_d = theta;
                     x_d = K_C;
                     y_d = '0;
                  end
               endcase
            end
         end
         ROT: begin
            if (!z_q[31]) begin
               x_d = x_q - ys;
               y_d = y_q + xs;
               z_d = z_q - atan;
            end else begin
               x_d = x_q + ys;
               y_d = y_q - xs;
               z_d = z_q + atan;
            end
            i_d = i_q + 5'd1;
            if (i_q == 5'(ITER - 1)) begin
               state_d     = DONE;
               res_valid_d = 1'b1;
               cos_d       = x_d;
               sin_d       = y_d;
               res_id_d    = id_q;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d     = IDLE;
               res_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         i_q         <= '0;
         id_q        <= '0;
         res_id_q    <= '0;
         cos_q       <= '0;
         sin_q       <= '0;
         res_valid_q <= 1'b0;
`ifdef CORDIC_SCHED_RR_EN
         p_q         <= '0;
`endif
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         i_q         <= i_d;
         id_q        <= id_d;
         res_id_q    <= res_id_d;
         cos_q       <= cos_d;
         sin_q       <= sin_d;
         res_valid_q <= res_valid_d;
`ifdef CORDIC_SCHED_RR_EN
         p_q         <= p_d;
`endif
      end
   end

   assign res_valid = res_valid_q;
   assign res_id    = res_id_q;
   assign cos       = cos_q;
   assign sin       = sin_q;
   assign busy      = (state_q != IDLE) && !rst;

endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: directed vectors plus a randomized sweep against a
// floating-point sin/cos model for cordic_sched (NREQ=4, ITER=24).
module tb_cordic_sched;

   localparam int NREQ = 4;
   localparam int ITER = 24;
   localparam int IDW  = 2;
   localparam int LAT  = ITER + 1;
   localparam longint TOL  = 256;
   localparam longint ONE  = 64'sd1073741824;
   localparam longint C45  = 64'sd759250125;
   localparam int NSWEEP = 1000;

`ifdef CORDIC_SCHED_RR_EN
   localparam int NG = 5;
   int exp_g [NG] = '{0, 1, 2, 3, 0};
`else
   localparam int NG = 3;
   int exp_g [NG] = '{0, 0, 0};
`endif

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [32*NREQ-1:0]  req_theta = '0;
   logic [NREQ-1:0]     req_ready;
   logic                res_valid;
   logic                res_ready = 1'b0;
   logic [IDW-1:0]      res_id;
   logic [31:0]         cos_o, sin_o;
   logic                busy;

   int cyc    = 0;
   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      int          id;
      logic [31:0] th;
   } exp_t;

   exp_t q [$];

   cordic_sched #(.NREQ(NREQ), .ITER(ITER)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_theta (req_theta),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_id    (res_id),
      .cos       (cos_o),
      .sin       (sin_o),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input longint got,
                        input longint exp, input longint tol = 0);
      longint d;
      d = got - exp;
      if (d < 0) d = -d;
      n_chk++;
      if (d > tol)
         $display("FAIL %s: got %0d, expected %0d (+/-%0d)",
                  tag, got, exp, tol);
      else
         n_pass++;
   endtask

   function automatic longint ideal(input logic [31:0] th, input bit want_sin);
      real a, v;
      a = $itor($signed(th)) * 3.141592653589793 / 2147483648.0;
      v = want_sin ? $sin(a) : $cos(a);
      return longint'($rtoi($floor(v * 1073741824.0 + 0.5)));
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic wait_grant(input int k, output int t);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready[k] && n < 200);
      check("grant_timeout", longint'(req_ready[k]), 1);
      t = cyc;
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
   endtask

   task automatic wait_result(output int u);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!res_valid && n < 200);
      check("res_timeout", longint'(res_valid), 1);
      u = cyc;
   endtask

   task automatic do_op(input int k, input logic [31:0] th,
                        input longint ec, input longint es, input string tag);
      int t, u;
      res_ready = 1'b1;
      req_theta[32*k +: 32] = th;
      req_valid[k] = 1'b1;
      wait_grant(k, t);
      wait_result(u);
      check({tag, "_lat"}, u - t, LAT);
      check({tag, "_id"}, longint'(res_id), k);
      check({tag, "_cos"}, longint'($signed(cos_o)), ec, TOL);
      check({tag, "_sin"}, longint'($signed(sin_o)), es, TOL);
      @(posedge clk); #1;
   endtask

   initial begin
      int t, u, ng, n, done, issued;
      logic [31:0] c0, s0;
      int gid [NG];
      int gcyc [NG];
      logic [31:0] th [NREQ];
      bit pend [NREQ];
      exp_t e;

      // Reset cycle: a valid request must not be granted.
      req_valid = '1;
      @(negedge clk);
      check("rst_ready", longint'(req_ready), 0);
      check("rst_busy", longint'(busy), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      req_valid = '0;
      @(negedge clk);
      check("init_busy", longint'(busy), 0);
      check("init_valid", longint'(res_valid), 0);
      check("init_cos", longint'(cos_o), 0);
      check("init_sin", longint'(sin_o), 0);
      check("init_id", longint'(res_id), 0);
      check("init_ready", longint'(req_ready), 0);
      @(posedge clk); #1;

      do_op(0, 32'h00000000, ONE, 0, "zero");
      do_op(1, 32'h20000000, C45, C45, "q1");
      do_op(2, 32'h60000000, -C45, C45, "q2");
      do_op(3, 32'h80000000, -ONE, 0, "neg_pi");
      do_op(1, 32'hA0000000, -C45, -C45, "q3");
      do_op(0, 32'hC0000000, 0, -ONE, "neg_half");

      // Reset at iteration 10 of an in-flight operation.
      res_ready = 1'b1;
      req_theta[31:0] = 32'h20000000;
      req_valid[0] = 1'b1;
      wait_grant(0, t);
      repeat (9) @(posedge clk);
      @(negedge clk);
      check("mid_busy", longint'(busy), 1);
      @(posedge clk); #1;
      rst = 1'b1;
      req_theta[95:64] = 32'hE0000000;
      req_valid[2] = 1'b1;
      @(negedge clk);
      check("mid_rst_busy", longint'(busy), 0);
      check("mid_rst_ready", longint'(req_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_busy0", longint'(busy), 0);
      check("mid_valid0", longint'(res_valid), 0);
      check("mid_cos0", longint'(cos_o), 0);
      check("mid_sin0", longint'(sin_o), 0);
      check("mid_id0", longint'(res_id), 0);
      check("mid_grant2", longint'(req_ready), 4);
      t = cyc;
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      wait_result(u);
      check("mid_lat", u - t, LAT);
      check("mid_id", longint'(res_id), 2);
      check("mid_cos", longint'($signed(cos_o)), C45, TOL);
      check("mid_sin", longint'($signed(sin_o)), -C45, TOL);
      @(posedge clk); #1;

      // Backpressure in DONE with another client waiting.
      res_ready = 1'b0;
      req_theta[127:96] = 32'h20000000;
      req_valid[3] = 1'b1;
      wait_grant(3, t);
      req_theta[63:32] = 32'h00000000;
      req_valid[1] = 1'b1;
      wait_result(u);
      check("bp_lat", u - t, LAT);
      c0 = cos_o;
      s0 = sin_o;
      check("bp_cos", longint'($signed(c0)), C45, TOL);
      check("bp_sin", longint'($signed(s0)), C45, TOL);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("bp_valid", longint'(res_valid), 1);
         check("bp_hold_cos", longint'(cos_o), longint'(c0));
         check("bp_hold_sin", longint'(sin_o), longint'(s0));
         check("bp_id", longint'(res_id), 3);
         check("bp_ready", longint'(req_ready), 0);
      end
      @(posedge clk); #1;
      res_ready = 1'b1;
      @(negedge clk);
      check("bp_rel_valid", longint'(res_valid), 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_idle", longint'(busy), 0);
      check("bp_next_grant", longint'(req_ready), 2);
      check("bp_after_cos", longint'(cos_o), longint'(c0));
      check("bp_after_id", longint'(res_id), 3);
      t = cyc;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      wait_result(u);
      check("bp2_lat", u - t, LAT);
      check("bp2_id", longint'(res_id), 1);
      check("bp2_cos", longint'($signed(cos_o)), ONE, TOL);
      @(posedge clk); #1;

      // Arbitration with every client requesting continuously.
      do_reset();
      res_ready = 1'b1;
      for (int k = 0; k < NREQ; k++)
         req_theta[32*k +: 32] = 32'(k) << 28;
      req_valid = '1;
      ng = 0;
      n = 0;
      while (ng < NG && n < 400) begin
         @(negedge clk);
         n++;
         for (int k = 0; k < NREQ; k++) begin
            if (req_valid[k] && req_ready[k] && ng < NG) begin
               gid[ng] = k;
               gcyc[ng] = cyc;
               ng++;
            end
         end
      end
      check("arb_count", ng, NG);
      for (int g = 0; g < ng; g++) begin
         check($sformatf("arb_id%0d", g), gid[g], exp_g[g]);
         if (g > 0)
            check($sformatf("arb_gap%0d", g), gcyc[g] - gcyc[g-1], ITER + 2);
      end
      req_valid = '0;
      do_reset();

      // Random sweep with random clients and result stalls.
      for (int k = 0; k < NREQ; k++) pend[k] = 1'b0;
      done = 0;
      issued = 0;
      n = 0;
      while (done < NSWEEP && n < 80000) begin
         @(negedge clk);
         n++;
         for (int k = 0; k < NREQ; k++) begin
            if (req_valid[k] && req_ready[k]) begin
               q.push_back('{id: k, th: th[k]});
               pend[k] = 1'b0;
            end
         end
         if (res_valid && res_ready) begin
            check("sweep_extra", q.size(), 1, 64'sd1000000);
            if (q.size() > 0) begin
               e = q.pop_front();
               check("sweep_id", longint'(res_id), e.id);
               check("sweep_cos", longint'($signed(cos_o)),
                     ideal(e.th, 1'b0), TOL);
               check("sweep_sin", longint'($signed(sin_o)),
                     ideal(e.th, 1'b1), TOL);
               done++;
            end
         end
         @(posedge clk); #1;
         for (int k = 0; k < NREQ; k++) begin
            req_valid[k] = pend[k];
            if (!pend[k] && issued < NSWEEP && $urandom_range(0, 3) == 0) begin
               th[k] = $urandom;
               req_theta[32*k +: 32] = th[k];
               req_valid[k] = 1'b1;
               pend[k] = 1'b1;
               issued++;
            end
         end
         res_ready = ($urandom_range(0, 3) != 0);
      end
      check("sweep_done", done, NSWEEP);
      check("sweep_issued", issued, NSWEEP);
      check("sweep_left", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
